// File: rtl/io_resp_fx_if.sv
// Port bundle between io_resp_fx and its surroundings: core read/write side and
// external valid/ready input buffers, output strobes and interrupt.
interface io_resp_fx_if #(
    parameter int NUBITS = 32,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8
);
    localparam int AWI = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
    localparam int AWO = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

    logic                     req_in;
    logic [AWI-1:0]           addr_in;
    logic [NUBITS-1:0]        io_in;
    logic                     out_en;
    logic [AWO-1:0]           addr_out;
    logic [NUBITS-1:0]        data_out;
    logic [NUIOIN*NUBITS-1:0] in_data;
    logic [NUIOIN-1:0]        in_vld;
    logic [NUIOIN-1:0]        in_rdy;
    logic [NUIOOU*NUBITS-1:0] out_data;
    logic [NUIOOU-1:0]        out_stb;
    logic [NUIOIN-1:0]        underrun;
    logic                     itr;

    modport master (
        output req_in, addr_in, out_en, addr_out, data_out, in_data, in_vld,
        input  io_in, in_rdy, out_data, out_stb, underrun, itr
    );

    modport slave (
        input  req_in, addr_in, out_en, addr_out, data_out, in_data, in_vld,
        output io_in, in_rdy, out_data, out_stb, underrun, itr
    );
endinterface

// File: rtl/io_resp_fx.sv
// I/O responder for the fixed-point core: one-entry input buffers with
// zero-latency reads, registered output ports with strobes, and a spaced interrupt.
module io_resp_fx #(
    parameter int                NUBITS = 32,
    parameter int                NUIOIN = 8,
    parameter int                NUIOOU = 8,
    parameter logic [NUIOIN-1:0] ITRMSK = '0,
    parameter int                ITRGAP = 4
) (
    input  logic         clk,
    input  logic         rst,
    io_resp_fx_if.slave  bus
);
    localparam int AWI = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
    localparam int AWO = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;
    localparam int GW  = (ITRGAP > 1) ? $clog2(ITRGAP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRE  = 2'd1,
        ST_SERVE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    logic [NUIOIN-1:0][NUBITS-1:0] hold_q, hold_d;
    logic [NUIOIN-1:0]             vld_q, vld_d;
    logic [NUIOIN-1:0]             unr_q, unr_d;
    logic [NUIOIN-1:0]             consume_s, accept_s, rdy_s;
    logic [NUBITS-1:0]             rd_s;
    logic [NUIOOU-1:0][NUBITS-1:0] out_q, out_d;
    logic [NUIOOU-1:0]             stb_q, wr_s;
    state_t                        state_q, state_d;
    logic [GW-1:0]                 gap_q, gap_d;
    logic                          itr_q;
    logic                          pend_s, mask_rd_s;

    // Input buffers: read mux, consume/accept decode and underrun flags
    always_comb begin
        consume_s = '0;
        accept_s  = '0;
        rdy_s     = '0;
        rd_s      = '0;
        hold_d    = hold_q;
        vld_d     = vld_q;
        unr_d     = unr_q;
        for (int i = 0; i < NUIOIN; i++) begin
            if ((NUIOIN == 1) || (bus.addr_in == AWI'(i))) begin
                rd_s         = hold_q[i];
                consume_s[i] = bus.req_in;
            end else begin
                consume_s[i] = 1'b0;
            end
            rdy_s[i]    = ~vld_q[i] | consume_s[i];
            accept_s[i] = bus.in_vld[i] & rdy_s[i];
            if (accept_s[i]) begin
                hold_d[i] = bus.in_data[i*NUBITS +: NUBITS];
                vld_d[i]  = 1'b1;
            end else if (consume_s[i]) begin
                vld_d[i]  = 1'b0;
            end else begin
                vld_d[i]  = vld_q[i];
            end
            if (consume_s[i] & ~vld_q[i]) begin
                unr_d[i] = 1'b1;
            end else begin
                unr_d[i] = unr_q[i];
            end
        end
    end

    // Output port write decode
    always_comb begin
        wr_s  = '0;
        out_d = out_q;
        for (int j = 0; j < NUIOOU; j++) begin
            if (bus.out_en && ((NUIOOU == 1) || (bus.addr_out == AWO'(j)))) begin
                wr_s[j]  = 1'b1;
                out_d[j] = bus.data_out;
            end else begin
                wr_s[j]  = 1'b0;
            end
        end
    end

    assign pend_s    = |(vld_q & ITRMSK);
    assign mask_rd_s = |(consume_s & ITRMSK);

    // Interrupt FSM next state; only a masked read leaves SERVE
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (pend_s) begin
                    state_d = ST_FIRE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FIRE: begin
                state_d = ST_SERVE;
            end
            ST_SERVE: begin
                if (mask_rd_s) begin
                    gap_d   = '0;
                    state_d = (ITRGAP == 0) ? ST_IDLE : ST_HOLD;
                end else begin
                    state_d = ST_SERVE;
                end
            end
            ST_HOLD: begin
                if (int'(gap_q) >= ITRGAP - 1) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d   = gap_q + GW'(1);
                    state_d = ST_HOLD;
                end
            end
            default: begin
                gap_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset clears everything including a HOLD in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q  <= '0;
            vld_q   <= '0;
            unr_q   <= '0;
            out_q   <= '0;
            stb_q   <= '0;
            state_q <= ST_IDLE;
            gap_q   <= '0;
            itr_q   <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            vld_q   <= vld_d;
            unr_q   <= unr_d;
            out_q   <= out_d;
            stb_q   <= wr_s;
            state_q <= state_d;
            gap_q   <= gap_d;
            itr_q   <= (state_d == ST_FIRE);
        end
    end

    assign bus.io_in    = rd_s;
    assign bus.in_rdy   = rdy_s;
    assign bus.out_data = out_q;
    assign bus.out_stb  = stb_q;
    assign bus.underrun = unr_q;
    assign bus.itr      = itr_q;
endmodule

// File: tb/tb_io_resp_fx.sv
// Directed bench for io_resp_fx: a vector table for buffer/port behaviour plus
// hand-written interrupt spacing and asynchronous reset sequences.
module tb_io_resp_fx;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    io_resp_fx_if #(.NUBITS(32), .NUIOIN(8), .NUIOOU(8)) bus ();

    io_resp_fx #(
        .NUBITS(32), .NUIOIN(8), .NUIOOU(8), .ITRMSK(8'h01), .ITRGAP(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        req;
        logic [2:0]  ain;
        logic        oen;
        logic [2:0]  aout;
        logic [31:0] dout;
        logic [7:0]  ivld;
        logic [31:0] idat;
        logic [31:0] e_io;
        logic [7:0]  e_rdy;
        logic [7:0]  e_stb;
        logic [7:0]  e_unr;
        logic [31:0] e_out3;
    } vec_t;

    vec_t tv [19];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic req, input logic [2:0] ain, input logic oen,
                                input logic [2:0] aout, input logic [31:0] dout,
                                input logic [7:0] ivld, input logic [31:0] idat,
                                input logic [31:0] e_io, input logic [7:0] e_rdy,
                                input logic [7:0] e_stb, input logic [7:0] e_unr,
                                input logic [31:0] e_out3);
        vec_t v;
        v.req = req; v.ain = ain; v.oen = oen; v.aout = aout; v.dout = dout;
        v.ivld = ivld; v.idat = idat; v.e_io = e_io; v.e_rdy = e_rdy;
        v.e_stb = e_stb; v.e_unr = e_unr; v.e_out3 = e_out3;
        return v;
    endfunction

    task automatic drive(input logic req, input logic [2:0] ain, input logic oen,
                         input logic [2:0] aout, input logic [31:0] dout,
                         input logic [7:0] ivld, input logic [31:0] idat);
        bus.req_in   = req;
        bus.addr_in  = ain;
        bus.out_en   = oen;
        bus.addr_out = aout;
        bus.data_out = dout;
        bus.in_vld   = ivld;
        bus.in_data  = {8{idat}};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    initial begin
        //          req  ain   oen  aout  dout       ivld   idat       e_io       e_rdy  e_stb  e_unr  e_out3
        tv[0]  = mk(1'b0, 3'd0, 1'b0, 3'd0, 32'h0,    8'h00, 32'h0,    32'h0,    8'hFF, 8'h00, 8'h00, 32'h0);
        tv[1]  = mk(1'b0, 3'd0, 1'b1, 3'd3, 32'h1234, 8'h00, 32'h0,    32'h0,    8'hFF, 8'h00, 8'h00, 32'h0);
        tv[2]  = mk(1'b0, 3'd0, 1'b0, 3'd0, 32'h0,    8'h00, 32'h0,    32'h0,    8'hFF, 8'h08, 8'h00, 32'h1234);
        tv[3]  = mk(1'b0, 3'd0, 1'b0, 3'd0, 32'h0,    8'h00, 32'h0,    32'h0,    8'hFF, 8'h00, 8'h00, 32'h1234);
        tv[4]  = mk(1'b0, 3'd0, 1'b0, 3'd0, 32'h0,    8'h04, 32'hCAFE, 32'h0,    8'hFF, 8'h00, 8'h00, 32'h1234);
        tv[5]  = mk(1'b0, 3'd2, 1'b0, 3'd0, 32'h0,    8'h00, 32'h0,    32'hCAFE, 8'hFB, 8'h00, 8'h00, 32'h1234);
        tv[6]  = mk(1'b1, 3'd2, 1'b0, 3'd0, 32'h0,    8'h00, 32'h0,    32'hCAFE, 8'hFF, 8'h00, 8'h00, 32'h1234);
        tv[7]  = mk(1'b0, 3'd2, 1'b0, 3'd0, 32'h0,    8'h00, 32'h0,    32'hCAFE, 8'hFF, 8'h00, 8'h00, 32'h1234);
        tv[8]  = mk(1'b0, 3'd5, 1'b0, 3'd0, 32'h0,    8'h20, 32'hA,    32'h0,    8'hFF, 8'h00, 8'h00, 32'h1234);
        tv[9]  = mk(1'b1, 3'd5, 1'b0, 3'd0, 32'h0,    8'h20, 32'hB,    32'hA,    8'hFF, 8'h00, 8'h00, 32'h1234);
        tv[10] = mk(1'b0, 3'd5, 1'b0, 3'd0, 32'h0,    8'h00, 32'h0,    32'hB,    8'hDF, 8'h00, 8'h00, 32'h1234);
        tv[11] = mk(1'b1, 3'd5, 1'b0, 3'd0, 32'h0,    8'h00, 32'h0,    32'hB,    8'hFF, 8'h00, 8'h00, 32'h1234);
        tv[12] = mk(1'b0, 3'd5, 1'b0, 3'd0, 32'h0,    8'h00, 32'h0,    32'hB,    8'hFF, 8'h00, 8'h00, 32'h1234);
        tv[13] = mk(1'b1, 3'd1, 1'b0, 3'd0, 32'h0,    8'h00, 32'h0,    32'h0,    8'hFF, 8'h00, 8'h00, 32'h1234);
        tv[14] = mk(1'b0, 3'd1, 1'b0, 3'd0, 32'h0,    8'h00, 32'h0,    32'h0,    8'hFF, 8'h00, 8'h02, 32'h1234);
        tv[15] = mk(1'b0, 3'd0, 1'b1, 3'd3, 32'h5555, 8'h00, 32'h0,    32'h0,    8'hFF, 8'h00, 8'h02, 32'h1234);
        tv[16] = mk(1'b0, 3'd0, 1'b1, 3'd3, 32'h6666, 8'h00, 32'h0,    32'h0,    8'hFF, 8'h08, 8'h02, 32'h5555);
        tv[17] = mk(1'b0, 3'd0, 1'b0, 3'd0, 32'h0,    8'h00, 32'h0,    32'h0,    8'hFF, 8'h08, 8'h02, 32'h6666);
        tv[18] = mk(1'b0, 3'd0, 1'b0, 3'd0, 32'h0,    8'h00, 32'h0,    32'h0,    8'hFF, 8'h00, 8'h02, 32'h6666);

        rst = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 3'd0, 32'h0, 8'h00, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", 32'(bus.in_rdy), 32'hFF);
        chk("rst_io", bus.io_in, 32'h0);
        chk("rst_itr_stb", 32'({bus.itr, bus.out_stb}), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            next_cycle();
            drive(tv[i].req, tv[i].ain, tv[i].oen, tv[i].aout, tv[i].dout, tv[i].ivld, tv[i].idat);
            @(negedge clk);
            n_vec++;
            if (bus.io_in !== tv[i].e_io || bus.in_rdy !== tv[i].e_rdy ||
                bus.out_stb !== tv[i].e_stb || bus.underrun !== tv[i].e_unr ||
                bus.out_data[3*32 +: 32] !== tv[i].e_out3 || bus.itr !== 1'b0 ||
                bus.out_data[2*32 +: 32] !== 32'h0) begin
                n_err++;
                $display("FAIL vec%0d: got io=%h rdy=%h stb=%h unr=%h out3=%h itr=%b, expected io=%h rdy=%h stb=%h unr=%h out3=%h itr=0",
                         i, bus.io_in, bus.in_rdy, bus.out_stb, bus.underrun,
                         bus.out_data[3*32 +: 32], bus.itr, tv[i].e_io, tv[i].e_rdy,
                         tv[i].e_stb, tv[i].e_unr, tv[i].e_out3);
            end
        end

        // Interrupt: push masked port 0, itr only in the second cycle after the edge
        next_cycle();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 32'h0, 8'h01, 32'h77);
        @(negedge clk);
        chk("itr_push", 32'(bus.itr), 32'h0);
        next_cycle();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 32'h0, 8'h00, 32'h0);
        @(negedge clk);
        chk("itr_n1", 32'(bus.itr), 32'h0);
        chk("rdy_full0", 32'(bus.in_rdy), 32'hFE);
        next_cycle();
        @(negedge clk);
        chk("itr_n2", 32'(bus.itr), 32'h1);
        next_cycle();
        @(negedge clk);
        chk("itr_n3", 32'(bus.itr), 32'h0);

        // Service with immediate refill; next pulse no earlier than ITRGAP+2 cycles
        next_cycle();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 32'h0, 8'h01, 32'h88);
        @(negedge clk);
        chk("svc_io", bus.io_in, 32'h77);
        for (int d = 1; d <= 5; d++) begin
            next_cycle();
            drive(1'b0, 3'd0, 1'b0, 3'd0, 32'h0, 8'h00, 32'h0);
            @(negedge clk);
            chk($sformatf("gap_itr%0d", d), 32'(bus.itr), 32'h0);
        end
        next_cycle();
        @(negedge clk);
        chk("gap_itr6", 32'(bus.itr), 32'h1);
        next_cycle();
        @(negedge clk);
        chk("gap_itr7", 32'(bus.itr), 32'h0);
        chk("unr_sticky", 32'(bus.underrun), 32'h02);

        // Reset during HOLD with a strobe pending
        next_cycle();
        drive(1'b1, 3'd0, 1'b1, 3'd1, 32'h9, 8'h00, 32'h0);
        @(negedge clk);
        chk("hold_io", bus.io_in, 32'h88);
        next_cycle();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 32'h0, 8'h00, 32'h0);
        chk("pre_rst_stb", 32'(bus.out_stb), 32'h02);
        rst = 1'b1;
        #1;
        chk("arst_stb", 32'(bus.out_stb), 32'h0);
        chk("arst_out", 32'(|bus.out_data), 32'h0);
        chk("arst_rdy_io", 32'(bus.in_rdy) ^ bus.io_in, 32'hFF);
        chk("arst_itr_unr", 32'({bus.itr, bus.underrun}), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        next_cycle();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 32'h0, 8'h01, 32'h5);
        @(negedge clk);
        chk("post_push", 32'(bus.itr), 32'h0);
        next_cycle();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 32'h0, 8'h00, 32'h0);
        @(negedge clk);
        chk("post_n1_itr", 32'(bus.itr), 32'h0);
        chk("post_n1_io", bus.io_in, 32'h5);
        next_cycle();
        @(negedge clk);
        chk("post_n2_itr", 32'(bus.itr), 32'h1);
        next_cycle();
        @(negedge clk);
        chk("post_n3_itr", 32'(bus.itr), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
